tick_debouncer: RTL

TICK_DEBOUNCER -- requirements
Module: tick_debouncer

---
 rtl/tick_debouncer_pkg.sv | 18 +
 rtl/sync_2ff.sv | 29 ++
 rtl/tick_debouncer.sv | 97 +++++++++
 3 files changed

// File: rtl/tick_debouncer_pkg.sv
// Shared constants for the tick-driven debouncer and the binary counter family
// that supplies its sampling tick.
package tick_debouncer_pkg;

    localparam int CTR_W   = 8;
    localparam int CTR_MAX = (1 << CTR_W) - 1;

    localparam int DEF_STABLE_TICKS = 3;
    localparam int DEF_CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } db_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages clear on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/tick_debouncer.sv
// Debounces a raw switch level: a new level is accepted only after it persists
// for STABLE_TICKS sampling ticks; emits registered rise/fall pulses on acceptance.
module tick_debouncer
    import tick_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_TICKS);

    logic             sw_s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             db_level_q, db_level_d;
    logic             db_rise_q, db_rise_d;
    logic             db_fall_q, db_fall_d;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sw),
        .q       (sw_s)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_LOW;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            db_rise_q  <= 1'b0;
            db_fall_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            db_rise_q  <= db_rise_d;
            db_fall_q  <= db_fall_d;
        end
    end

    // Abort is checked before tick so a colliding tick is never counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cnt_inc = cnt_q + CNT_W'(1);
        case (state_q)
            ST_LOW: begin
                if (sw_s) state_d = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (!sw_s) begin
                    state_d = ST_LOW;
                end else if (tick) begin
                    if (cnt_inc == STABLE_CNT) state_d = ST_HIGH;
                    else                       cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_HIGH: begin
                if (!sw_s) state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (sw_s) begin
                    state_d = ST_HIGH;
                end else if (tick) begin
                    if (cnt_inc == STABLE_CNT) state_d = ST_LOW;
                    else                       cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: state_d = ST_LOW;
        endcase
    end

    // Outputs derive from the next state so they register on the same edge as state_q.
    always_comb begin
        db_level_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
        db_rise_d  = (state_q == ST_WAIT_HIGH) && (state_d == ST_HIGH);
        db_fall_d  = (state_q == ST_WAIT_LOW)  && (state_d == ST_LOW);
    end

    assign db_level = db_level_q;
    assign db_rise  = db_rise_q;
    assign db_fall  = db_fall_q;

endmodule
